// File: rtl/float_to_ieee_packer_if.sv
// Handshake bundle between the coprocessor result path and the IEEE packer.
// in_* carries the internal float in, out_* carries the packed single out.
interface float_to_ieee_packer_if #(
   parameter int Nm = 23,
   parameter int Ne = 8
) ();
   logic              in_valid;
   logic              in_ready;
   logic [Ne+Nm+2:0]  in_float;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_ieee;
   logic              out_ovf;
   logic              out_unf;

   modport master (
      output in_valid, in_float, out_ready,
      input  in_ready, out_valid, out_ieee, out_ovf, out_unf
   );

   modport slave (
      input  in_valid, in_float, out_ready,
      output in_ready, out_valid, out_ieee, out_ovf, out_unf
   );
endinterface

// File: rtl/float_to_ieee_packer.sv
// Serial normalize, round-nearest-even and bias of the internal float
// into an IEEE-754 single; one operation in flight at a time.
module float_to_ieee_packer #(
   parameter int Nm = 23,
   parameter int Ne = 8
) (
   input logic                clk_i,
   input logic                rst_i,
   float_to_ieee_packer_if.slave bus
);
   localparam int EW = Ne + 3 + $clog2(Nm + 2);
   localparam logic signed [EW-1:0] ONE  = EW'(1);
   localparam logic signed [EW-1:0] BIAS = EW'(127);
   localparam logic signed [EW-1:0] EMAX = EW'(255);
   localparam logic signed [EW-1:0] EMIN = EW'(0);

   typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_e;

   state_e                 state_q, state_d;
   logic                   s_q, s_d;
   logic signed [EW-1:0]   exp_q, exp_d;
   logic [Nm:0]            mant_q, mant_d;
   logic [22:0]            frac_q, frac_d;
   logic                   zero_q, zero_d;
   logic                   vld_q, vld_d;
   logic [31:0]            ieee_q, ieee_d;
   logic                   ovf_q, ovf_d;
   logic                   unf_q, unf_d;

   logic signed [Ne:0]     in_exp;
   logic signed [EW-1:0]   eb;
   logic [22:0]            rnd_frac;
   logic                   rnd_carry;

   assign in_exp = bus.in_float[Nm+Ne+1:Nm+1];
   assign eb     = exp_q + BIAS;

   // The hidden bit is always 1 here, so carry-out only on an all-ones fraction.
   if (Nm > 23) begin : g_rnd
      logic [22:0] kept;
      logic        guard;
      logic        sticky;
      logic        up;
      assign kept  = mant_q[Nm-1 -: 23];
      assign guard = mant_q[Nm-24];
      if (Nm > 24) begin : g_st
         assign sticky = |mant_q[Nm-25:0];
      end else begin : g_nst
         assign sticky = 1'b0;
      end
      assign up        = guard & (sticky | kept[0]);
      assign rnd_frac  = kept + 23'(up);
      assign rnd_carry = up & (&kept);
   end else begin : g_pad
      assign rnd_frac  = 23'(mant_q[Nm-1:0]) << (23 - Nm);
      assign rnd_carry = 1'b0;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (bus.in_valid) state_d = NORM;
         NORM: begin
            if (mant_q == '0)     state_d = OUT;
            else if (mant_q[Nm])  state_d = ROUND;
         end
         ROUND: state_d = OUT;
         OUT:   if (vld_q && bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      s_d    = s_q;
      exp_d  = exp_q;
      mant_d = mant_q;
      frac_d = frac_q;
      zero_d = zero_q;
      vld_d  = vld_q;
      ieee_d = ieee_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               s_d    = bus.in_float[Nm+Ne+2];
               exp_d  = EW'(in_exp);
               mant_d = bus.in_float[Nm:0];
               zero_d = 1'b0;
            end
         end
         NORM: begin
            if (mant_q == '0) begin
               zero_d = 1'b1;
            end else if (!mant_q[Nm]) begin
               mant_d = mant_q << 1;
               exp_d  = exp_q - ONE;
            end
         end
         ROUND: begin
            frac_d = rnd_frac;
            if (rnd_carry) exp_d = exp_q + ONE;
         end
         OUT: begin
            if (!vld_q) begin
               vld_d = 1'b1;
               ovf_d = 1'b0;
               unf_d = 1'b0;
               if (zero_q) begin
                  ieee_d = {s_q, 31'b0};
               end else if (eb >= EMAX) begin
                  ieee_d = {s_q, 8'hFF, 23'b0};
                  ovf_d  = 1'b1;
               end else if (eb <= EMIN) begin
                  ieee_d = {s_q, 31'b0};
                  unf_d  = 1'b1;
               end else begin
                  ieee_d = {s_q, eb[7:0], frac_q};
               end
            end else if (bus.out_ready) begin
               vld_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s_q    <= 1'b0;
         exp_q  <= '0;
         mant_q <= '0;
         frac_q <= '0;
         zero_q <= 1'b0;
         vld_q  <= 1'b0;
         ieee_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         s_q    <= s_d;
         exp_q  <= exp_d;
         mant_q <= mant_d;
         frac_q <= frac_d;
         zero_q <= zero_d;
         vld_q  <= vld_d;
         ieee_q <= ieee_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = vld_q;
      bus.out_ieee  = ieee_q;
      bus.out_ovf   = ovf_q;
      bus.out_unf   = unf_q;
   end
endmodule

// File: tb/tb_float_to_ieee_packer.sv
// Bench for float_to_ieee_packer: Nm=23 and Nm=25 builds driven from one
// stimulus stream, checked against a value-level rounding model.
module tb_float_to_ieee_packer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   float_to_ieee_packer_if #(.Nm(23), .Ne(8)) ifa ();
   float_to_ieee_packer_if #(.Nm(25), .Ne(8)) ifb ();

   float_to_ieee_packer #(.Nm(23), .Ne(8)) u_a (
      .clk_i(clk), .rst_i(rst), .bus(ifa.slave));
   float_to_ieee_packer #(.Nm(25), .Ne(8)) u_b (
      .clk_i(clk), .rst_i(rst), .bus(ifb.slave));

   logic        sel, vld, rdy, fs;
   logic [8:0]  fe9;
   logic [25:0] fm;

   assign ifa.in_valid  = vld & ~sel;
   assign ifb.in_valid  = vld & sel;
   assign ifa.out_ready = rdy & ~sel;
   assign ifb.out_ready = rdy & sel;
   assign ifa.in_float  = {fs, fe9, fm[23:0]};
   assign ifb.in_float  = {fs, fe9, fm};

   logic        cur_ov, cur_ir, cur_ovf, cur_unf;
   logic [31:0] cur_ieee;
   assign cur_ov   = sel ? ifb.out_valid : ifa.out_valid;
   assign cur_ir   = sel ? ifb.in_ready  : ifa.in_ready;
   assign cur_ovf  = sel ? ifb.out_ovf   : ifa.out_ovf;
   assign cur_unf  = sel ? ifb.out_unf   : ifa.out_unf;
   assign cur_ieee = sel ? ifb.out_ieee  : ifa.out_ieee;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] ew, got;
   bit          eo, eu, active;
   int          el;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Exact value arithmetic: normalize, then compare the dropped remainder
   // against one half ulp to decide round-nearest-even.
   function automatic void model(input int nm, input bit s, input int e,
                                 input longint unsigned m,
                                 output logic [31:0] w, output bit ovf,
                                 output bit unf, output int lat);
      longint unsigned mn, kept, rem, half;
      int k, ee, eb, drop;
      ovf = 0;
      unf = 0;
      if (m == 0) begin
         w   = {s, 31'b0};
         lat = 2;
         return;
      end
      k  = 0;
      mn = m;
      while (mn < (64'd1 << nm)) begin
         mn = mn << 1;
         k++;
      end
      ee  = e - k;
      lat = 3 + k;
      if (nm > 23) begin
         drop = nm - 23;
         kept = mn >> drop;
         rem  = mn & ((64'd1 << drop) - 1);
         half = 64'd1 << (drop - 1);
         if (rem > half || (rem == half && kept[0])) kept++;
         if (kept == (64'd1 << 24)) begin
            kept = 64'd1 << 23;
            ee++;
         end
      end else begin
         kept = mn << (23 - nm);
      end
      eb = ee + 127;
      if (eb >= 255) begin
         w   = {s, 8'hFF, 23'b0};
         ovf = 1;
      end else if (eb <= 0) begin
         w   = {s, 31'b0};
         unf = 1;
      end else begin
         w = {s, eb[7:0], kept[22:0]};
      end
   endfunction

   always @(negedge clk) begin
      if (active && cur_ov) begin
         chk("out_ieee", cur_ieee, ew);
         chk("out_ovf", cur_ovf, eo);
         chk("out_unf", cur_unf, eu);
         got = cur_ieee;
      end
   end

   task automatic xfer(input bit sel_i, input bit s_i, input int e_i,
                       input longint unsigned m_i, input int stall);
      int n;
      int nm;
      nm  = sel_i ? 25 : 23;
      sel = sel_i;
      fs  = s_i;
      fe9 = e_i[8:0];
      fm  = m_i[25:0];
      model(nm, s_i, e_i, m_i, ew, eo, eu, el);
      vld = 1'b1;
      chk("in_ready_idle", cur_ir, 1);
      @(posedge clk);
      #1 vld = 1'b0;
      active = 1'b1;
      n = 0;
      while (!cur_ov && n < 300) begin
         @(posedge clk);
         #1 n++;
      end
      chk("latency", n, el);
      repeat (stall) begin
         chk("in_ready_busy", cur_ir, 0);
         @(posedge clk);
         #1;
      end
      rdy = 1'b1;
      @(posedge clk);
      #1 rdy = 1'b0;
      active = 1'b0;
      chk("out_valid_drop", cur_ov, 0);
      chk("in_ready_back", cur_ir, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      logic [31:0] w;
      bit          o, u;
      int          l, e, nm, st;
      longint unsigned m;

      rst = 1'b1; vld = 1'b0; rdy = 1'b0; sel = 1'b0;
      fs = 1'b0; fe9 = '0; fm = '0; active = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", ifa.in_ready, 1);
      chk("rst_out_valid", ifa.out_valid, 0);
      chk("rst_out_ieee", ifa.out_ieee, 0);
      chk("rst_out_ovf", ifa.out_ovf, 0);
      chk("rst_out_unf", ifa.out_unf, 0);
      chk("rst_b_valid", ifb.out_valid, 0);
      rst = 1'b0;

      model(23, 0, 0, 64'h800000, w, o, u, l);
      chk("pin_one", w, 32'h3F800000);
      chk("pin_one_lat", l, 3);
      model(25, 0, 0, 64'h3FFFFFF, w, o, u, l);
      chk("pin_carry", w, 32'h40000000);
      model(25, 0, 0, 64'h2000002, w, o, u, l);
      chk("pin_tie", w, 32'h3F800000);
      model(23, 0, 128, 64'h800000, w, o, u, l);
      chk("pin_ovf", {o, w}, {1'b1, 32'h7F800000});

      xfer(0, 0, 0, 64'h800000, 0);   chk("d_one", got, 32'h3F800000);
      xfer(0, 0, 23, 64'h1, 0);       chk("d_k23", got, 32'h3F800000);
      xfer(0, 1, 1, 64'h400000, 0);   chk("d_k1", got, 32'hBF800000);
      xfer(0, 1, 77, 64'h0, 0);       chk("d_zero", got, 32'h80000000);
      xfer(0, 0, 128, 64'h800000, 0); chk("d_ovf", got, 32'h7F800000);
      xfer(0, 1, -127, 64'h800000, 0);chk("d_unf", got, 32'h80000000);
      xfer(1, 0, 0, 64'h3FFFFFF, 0);  chk("d_carry", got, 32'h40000000);
      xfer(1, 0, 0, 64'h2000002, 0);  chk("d_tie", got, 32'h3F800000);
      xfer(1, 0, 0, 64'h2000006, 0);  chk("d_tie_up", got, 32'h3F800002);
      xfer(0, 0, 5, 64'h123456, 5);

      sel = 1'b0; fs = 1'b0; fe9 = '0; fm = 26'h10;
      vld = 1'b1;
      @(posedge clk);
      #1 vld = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_valid", ifa.out_valid, 0);
      chk("midrst_ready", ifa.in_ready, 1);
      repeat (30) @(posedge clk);
      #1 chk("midrst_quiet", ifa.out_valid, 0);
      xfer(0, 0, 2, 64'hC00000, 0);   chk("post_rst", got, 32'h40C00000);

      for (int i = 0; i < 150; i++) begin
         sel = 1'($urandom_range(0, 1));
         nm  = sel ? 25 : 23;
         m   = {$urandom, $urandom};
         m   = (m & ((64'd1 << (nm + 1)) - 1)) >> $urandom_range(0, nm + 1);
         e   = int'($urandom_range(0, 300)) - 150;
         st  = int'($urandom_range(0, 2));
         xfer(sel, 1'($urandom_range(0, 1)), e, m, st);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/float_to_ieee_packer.md
Name: float_to_ieee_packer

Overview:
- Multi-cycle converter from the coprocessor's internal float format to a 32-bit IEEE-754 single-precision word.
- Input format is the packed struct {s, exp[Ne:0], mant[Nm:0]}.
  - exp is a two's-complement unbiased exponent.
  - mant is an unsigned magnitude; bit Nm has weight 1.0.
  - value = (-1)^s * mant/2^Nm * 2^exp.
  - mant may be unnormalized (leading zeros after subtraction).
- Sits at the coprocessor result path, before the LM32 result register.
- Normalizes serially, rounds round-to-nearest-even, biases, and flags overflow/underflow. Denormal outputs are flushed to zero.

Parameters:
- Nm, 23, internal mantissa fraction bits (mant width Nm+1); Nm >= 2.
- Ne, 8, internal exponent width minus 1 (exp width Ne+1); Ne >= 2.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- in_valid  in  1  input float valid.
- in_ready  out  1  block can accept input.
- in_float  in  Ne+Nm+3  packed internal float {s, exp, mant}.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_ieee  out  32  IEEE-754 single result.
- out_ovf  out  1  result saturated to infinity (qualified by out_valid).
- out_unf  out  1  result flushed to zero from nonzero input (qualified by out_valid).

Behaviour:
- Reset, registered on clk_i when rst_i=1:
  - state=IDLE; in_ready=1; out_valid=0; out_ieee=0; out_ovf=0; out_unf=0.
  - Reset mid-operation discards the operation in progress.
- Internal exponent register is signed, width Ne+3+$clog2(Nm+2). It never wraps.
- IDLE:
  - in_ready=1.
  - On in_valid, capture s, sign-extended exp and mant, then go to NORM.
  - in_ready=0 in all other states.
- NORM, one decision per cycle:
  - mant==0 -> OUT with zero result {s,31'b0}; ovf=0, unf=0.
  - else mant[Nm]==1 -> ROUND.
  - else mant <<= 1, exp -= 1, stay in NORM. This takes at most Nm iterations.
- ROUND, single cycle:
  - Nm > 23:
    - keep mant[Nm:Nm-23].
    - guard = mant[Nm-24].
    - sticky = OR of mant[Nm-25:0] (0 if Nm=24).
    - round up iff guard & (sticky | kept lsb).
    - If round-up carries to 2.0: mantissa becomes 1.0, exp += 1.
  - Nm <= 23: zero-pad on the right; exact, no rounding.
  - Then go to OUT.
- OUT entry computes eb = exp + 127:
  - eb >= 255 -> out_ieee = {s, 8'hFF, 23'b0}, out_ovf=1.
  - eb <= 0 -> out_ieee = {s, 31'b0}, out_unf=1.
  - else out_ieee = {s, eb[7:0], frac[22:0]} (hidden bit dropped).
- OUT:
  - out_valid=1; out_ieee, out_ovf and out_unf are held stable while out_ready=0.
  - When out_valid & out_ready: out_valid falls next cycle, state returns to IDLE, and in_ready=1 that cycle.
  - No back-to-back overlap: one operation in flight.
- Latency from the accept edge to out_valid:
  - normalized nonzero input: 3 cycles.
  - input with k leading zeros: 3+k cycles.
  - zero input: 2 cycles.
- Sign is always passed through, including for zero, infinity and flush results.
- NaN is never produced.

Test Plan:
- Nm=23, Ne=8, in_float {0, 0, 0x800000}, out_ready=1 -> out_ieee=0x3F800000, ovf=0, unf=0; out_valid 3 cycles after accept.
- {0, 23, 0x000001} (k=23) -> 0x3F800000 after 26 cycles. Then {1, 1, 0x400000} -> 0xBF800000 (k=1, 4 cycles).
- {1, x, 0} -> 0x80000000, ovf=0, unf=0, out_valid 2 cycles after accept.
- {0, 128, 0x800000} -> 0x7F800000, ovf=1. {1, -127, 0x800000} -> 0x80000000, unf=1.
- Nm=25 build, {0, 0, 0x3FFFFFF} -> round carry -> 0x40000000. {0, 0, 0x2000002} (guard=1, sticky=0, lsb=0) -> 0x3F800000 (ties to even).
- Hold out_ready=0 for 5 cycles with a result pending -> out_ieee stable and in_ready=0 throughout. Assert rst_i during NORM -> next cycle out_valid=0, in_ready=1, IDLE.
